// File: rtl/frog_game_pkg.sv
// Shared types and score constants for the Frogger game-state controller.
package frog_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        DYING,
        LEVEL_UP,
        WIN,
        LOSE
    } game_state_e;

    localparam int unsigned HOME_PTS  = 10;
    localparam int unsigned LEVEL_PTS = 50;

endpackage

// File: rtl/frog_game_ctrl_frame_down_counter.sv
// Loadable, tick-enabled down-counter; stops at zero and flags its final count.
module frame_down_counter #(
    parameter int W       = 11,
    parameter int RST_VAL = 0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    // Set when the next decrement brings the count to zero.
    assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/frog_game_ctrl.sv
// Frogger game-state controller: bays, lives, level, per-life timer, score.
// Optional: define FROG_BONUS_LIFE_EN to grant a life on each non-final level-up.
//
// state    | meaning
// IDLE     | waiting for start_btn
// PLAY     | frog alive, timer running
// DYING    | respawn delay after a death
// LEVEL_UP | all bays filled, one-tick bonus/advance
// WIN      | all levels cleared, waits for start_btn
// LOSE     | no lives left, waits for start_btn
module frog_game_ctrl
    import frog_game_pkg::*;
#(
    parameter int NUM_HOMES      = 3,
    parameter int START_LIVES    = 3,
    parameter int MAX_LIVES      = 9,
    parameter int NUM_LEVELS     = 4,
    parameter int ROUND_FRAMES   = 1800,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCORE_W        = 16,
    localparam int IDX_W = (NUM_HOMES > 1) ? $clog2(NUM_HOMES) : 1,
    localparam int LVL_W = $clog2(NUM_LEVELS + 1),
    localparam int TW    = $clog2(ROUND_FRAMES + 1),
    localparam int RW    = $clog2(RESPAWN_FRAMES + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_tick_i,
    input  logic               start_btn_i,
    input  logic               dead_frog_i,
    input  logic               home_hit_i,
    input  logic [IDX_W-1:0]   home_idx_i,
    output logic [NUM_HOMES-1:0] home_filled_o,
    output logic [7:0]         frog_lives_o,
    output logic [LVL_W-1:0]   level_o,
    output logic [TW-1:0]      time_left_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               respawn_o,
    output logic               playing_o,
    output logic               win_game_o,
    output logic               lose_game_o
);

    game_state_e          state_q, state_d;
    logic [NUM_HOMES-1:0] mask_q, mask_d;
    logic [7:0]           lives_q, lives_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 respawn_q, respawn_d;

    logic t_load, t_dec, t_zero, t_last;
    logic d_load, d_dec, d_zero, d_last;
    logic [NUM_HOMES-1:0] hit_bit;
    logic hit_valid, bay_taken, death;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input int unsigned b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    frame_down_counter #(.W(TW), .RST_VAL(ROUND_FRAMES)) u_time_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(t_load),
        .load_val_i(TW'(ROUND_FRAMES)), .dec_i(t_dec),
        .count_o(time_left_o), .zero_o(t_zero), .last_o(t_last)
    );

    frame_down_counter #(.W(RW), .RST_VAL(0)) u_respawn_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(d_load),
        .load_val_i(RW'(RESPAWN_FRAMES)), .dec_i(d_dec),
        .count_o(), .zero_o(d_zero), .last_o(d_last)
    );

    // An out-of-range index shifts the bit out entirely, so it is simply ignored.
    assign hit_bit   = NUM_HOMES'(1) << home_idx_i;
    assign hit_valid = home_hit_i && (hit_bit != '0);
    assign bay_taken = hit_valid && ((mask_q & hit_bit) != '0);
    assign death     = dead_frog_i || t_last || t_zero || bay_taken;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        lives_d   = lives_q;
        level_d   = level_q;
        score_d   = score_q;
        respawn_d = 1'b0;
        t_load    = 1'b0;
        t_dec     = 1'b0;
        d_load    = 1'b0;
        d_dec     = 1'b0;
        if (frame_tick_i) begin
            unique case (state_q)
                IDLE, WIN, LOSE: begin
                    if (start_btn_i) begin
                        mask_d    = '0;
                        lives_d   = 8'(START_LIVES);
                        level_d   = LVL_W'(1);
                        score_d   = '0;
                        t_load    = 1'b1;
                        respawn_d = 1'b1;
                        state_d   = PLAY;
                    end
                end
                PLAY: begin
                    if (death) begin
                        // A timeout lets the timer land on zero; other deaths freeze it.
                        t_dec   = t_last;
                        lives_d = (lives_q == 8'd0) ? 8'd0 : lives_q - 8'd1;
                        if (lives_d == 8'd0) begin
                            state_d = LOSE;
                        end else begin
                            d_load  = 1'b1;
                            state_d = DYING;
                        end
                    end else if (hit_valid) begin
                        mask_d  = mask_q | hit_bit;
                        score_d = sat_add(score_q, HOME_PTS);
                        if (&mask_d) begin
                            state_d = LEVEL_UP;
                        end else begin
                            respawn_d = 1'b1;
                            t_load    = 1'b1;
                        end
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                DYING: begin
                    d_dec = 1'b1;
                    if (d_last || d_zero) begin
                        t_load    = 1'b1;
                        respawn_d = 1'b1;
                        state_d   = PLAY;
                    end
                end
                LEVEL_UP: begin
                    score_d = sat_add(score_q, LEVEL_PTS);
                    mask_d  = '0;
                    if (level_q == LVL_W'(NUM_LEVELS)) begin
                        state_d = WIN;
                    end else begin
                        level_d   = level_q + LVL_W'(1);
                        t_load    = 1'b1;
                        respawn_d = 1'b1;
                        state_d   = PLAY;
`ifdef FROG_BONUS_LIFE_EN
                        lives_d = (lives_q < 8'(MAX_LIVES)) ? lives_q + 8'd1 : 8'(MAX_LIVES);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            lives_q   <= 8'(START_LIVES);
            level_q   <= LVL_W'(1);
            score_q   <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            score_q   <= score_d;
            respawn_q <= respawn_d;
        end
    end

    assign home_filled_o = mask_q;
    assign frog_lives_o  = lives_q;
    assign level_o       = level_q;
    assign score_o       = score_q;
    assign respawn_o     = respawn_q;
    assign playing_o     = (state_q == PLAY);
    assign win_game_o    = (state_q == WIN);
    assign lose_game_o   = (state_q == LOSE);

endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
- Parametrised game-state controller for Frogger; successor to the fixed three-frog win/lose logic.
- Tracks home-bay occupancy, lives, level, per-life countdown timer and score.
- Sequences respawn delay, level-up, win and game-over.
- Sits between the frog/collision logic (event pulses in) and the sprite/HUD renderers (status out). Advances once per frame_tick.

Parameters:
- NUM_HOMES, 3, number of home bays (1..8).
- START_LIVES, 3, lives loaded at game start.
- MAX_LIVES, 9, lives ceiling.
- NUM_LEVELS, 4, levels to clear for a win.
- ROUND_FRAMES, 1800, frames allowed per life (30 s at 60 Hz).
- RESPAWN_FRAMES, 60, frames spent in DYING before respawn.
- SCORE_W, 16, score width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; returns the block to IDLE.
- frame_tick  in  1  one-Clk pulse per video frame; all game state advances only on it.
- start_btn  in  1  level-sensitive start/restart request.
- dead_frog  in  1  collision death, sampled on frame_tick.
- home_hit  in  1  frog entered a bay, sampled on frame_tick.
- home_idx  in  $clog2(NUM_HOMES)  bay index, valid with home_hit.
- home_filled  out  NUM_HOMES  occupied-bay mask.
- frog_lives  out  8  remaining lives.
- level  out  $clog2(NUM_LEVELS+1)  current level, 1-based.
- time_left  out  $clog2(ROUND_FRAMES+1)  frames left for the current life.
- score  out  SCORE_W  saturating score.
- respawn  out  1  one-Clk pulse telling frog logic to reset the frog position.
- playing, win_game, lose_game  out  1  status flags.

Behaviour:
- Reset (Clk edge with Reset=1): state=IDLE, home_filled=0, frog_lives=START_LIVES, level=1, time_left=ROUND_FRAMES, score=0, respawn=0, all flags 0. Reset overrides every other input.
- All transitions occur on Clk edges where frame_tick=1. Outputs are registered; they update on the edge that consumes the tick.
- IDLE: on start_btn, load the start values above, pulse respawn, go to PLAY.
- PLAY: playing=1. Per tick, events are checked in this priority order:
  - Death: dead_frog=1, time_left reaching 0, or home_hit into an already-filled bay. frog_lives decrements. If the result is 0, go to LOSE; otherwise go to DYING with the counter loaded to RESPAWN_FRAMES.
  - Valid home_hit (bay empty, home_idx<NUM_HOMES): set the bay bit, add 10 to score. If the mask is now all ones, go to LEVEL_UP. Otherwise pulse respawn and reload time_left.
  - Otherwise: decrement time_left.
- Death beats home_hit on the same tick. home_idx>=NUM_HOMES is ignored (no score, no death).
- DYING: playing=0. Count down RESPAWN_FRAMES ticks, then reload time_left, pulse respawn, go to PLAY.
- LEVEL_UP: add 50 to score, clear home_filled. If level==NUM_LEVELS, go to WIN. Otherwise increment level, reload time_left, pulse respawn, go to PLAY. Takes 1 tick.
- WIN: win_game=1. LOSE: lose_game=1. Both hold until start_btn, which re-enters the IDLE load path and starts a new game on that tick.
- start_btn is ignored in PLAY, DYING and LEVEL_UP.
- Score adds saturate at 2^SCORE_W-1. frog_lives never wraps below 0 or exceeds MAX_LIVES.
- Reset asserted mid-DYING or mid-LEVEL_UP aborts to IDLE immediately; no respawn pulse is issued.

Optional Feature:
- FROG_BONUS_LIFE_EN defined: each LEVEL_UP that does not end the game grants +1 life, clamped to MAX_LIVES.
- Undefined: lives change only on death.

Decomposition:
- Package frog_game_pkg holds:
  - state enum {IDLE, PLAY, DYING, LEVEL_UP, WIN, LOSE};
  - score constants HOME_PTS=10, LEVEL_PTS=50.
- One natural sub-module: frame_down_counter, a loadable tick-enabled down-counter with zero flag. It is instanced twice, for time_left and the respawn delay.

Test Plan:
- Reset, then start_btn on a tick -> PLAY, lives=3, level=1, time_left=1800, respawn pulsed once.
- home_hit idx 0, 1, 2 on separate ticks -> mask 001, 011, then LEVEL_UP; score=30+50=80, mask=000, level=2.
- dead_frog with lives=1 -> LOSE, lose_game=1, lives=0. Then start_btn -> PLAY with lives=3, score=0.
- home_hit idx 1 twice -> second hit is a death: lives 3->2, DYING for 60 ticks, then respawn, time_left=1800.
- No events for 1800 ticks -> timeout death. Same tick dead_frog+home_hit -> death only, mask unchanged.
- Clear all NUM_LEVELS=4 levels -> WIN, win_game=1, score=4*80=320. With FROG_BONUS_LIFE_EN, lives=3+3=6.
